// File: rtl/multi_ball_renderer.sv
// Three-stage pixel colour pipeline drawing N_BALLS filled circles over a safe-zone/background map.
// Ball state is shadowed once per frame; colour and o_disp_enbl trail the coordinates by 3 cycles.
module multi_ball_renderer #(
  parameter int SCREEN_WIDTH = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int N_BALLS = 4,
  parameter int BALL_RADIUS = 20,
  parameter logic [12*N_BALLS-1:0] BALL_COLORS = {N_BALLS{12'hF00}},
  parameter logic [11:0] SAFE_COLOR = 12'h0F0,
  parameter logic [11:0] BKG_COLOR = 12'h00F,
  parameter int BLINK_SHIFT = 4,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic [XW*N_BALLS-1:0] i_ball_x,
  input  logic [YW*N_BALLS-1:0] i_ball_y,
  input  logic [N_BALLS-1:0]    i_ball_en,
  input  logic [N_BALLS-1:0]    i_ball_blink,
  input  logic                  i_disp_enbl,
  input  logic [10:0]           i_h_coord,
  input  logic [9:0]            i_v_coord,
  output logic [XW-1:0]         o_screen_x,
  output logic [YW-1:0]         o_screen_y,
  output logic                  o_is_pixel_valid,
  input  logic                  i_is_safe,
  output logic [3:0]            o_red,
  output logic [3:0]            o_green,
  output logic [3:0]            o_blue,
  output logic                  o_disp_enbl
);

  localparam logic [10:0] H_LIMIT = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  V_LIMIT = 10'(SCREEN_HEIGHT);
  localparam logic [23:0] RADIUS_SQ = 24'(BALL_RADIUS * BALL_RADIUS);

  // Safe-map address path is purely combinational so the memory's 1-cycle read lines up with stage 2.
  assign o_screen_x       = i_h_coord[XW-1:0];
  assign o_screen_y       = i_v_coord[YW-1:0];
  assign o_is_pixel_valid = i_disp_enbl && (i_h_coord < H_LIMIT) && (i_v_coord < V_LIMIT);

  logic [XW*N_BALLS-1:0] x_sh;
  logic [YW*N_BALLS-1:0] y_sh;
  logic [N_BALLS-1:0]    en_sh;
  logic [N_BALLS-1:0]    blink_sh;
  logic [BLINK_SHIFT:0]  frame_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_sh      <= '0;
      y_sh      <= '0;
      en_sh     <= '0;
      blink_sh  <= '0;
      frame_cnt <= '0;
    end else if (i_frame_start) begin
      x_sh      <= i_ball_x;
      y_sh      <= i_ball_y;
      en_sh     <= i_ball_en;
      blink_sh  <= i_ball_blink;
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  logic [N_BALLS-1:0] visible;
  always_comb begin
    visible = '0;
    for (int k = 0; k < N_BALLS; k++) begin
      visible[k] = en_sh[k] && !(blink_sh[k] && frame_cnt[BLINK_SHIFT]);
    end
  end

  // Stage 1: signed offsets from each centre; widths cover every coordinate pair without wrap.
  logic signed [11:0] dx_d [N_BALLS];
  logic signed [10:0] dy_d [N_BALLS];
  logic signed [11:0] dx_q [N_BALLS];
  logic signed [10:0] dy_q [N_BALLS];
  logic               de1_q;

  always_comb begin
    for (int k = 0; k < N_BALLS; k++) begin
      dx_d[k] = 12'(i_h_coord) - 12'(x_sh[XW*k +: XW]);
      dy_d[k] = 11'(i_v_coord) - 11'(y_sh[YW*k +: YW]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_BALLS; k++) begin
        dx_q[k] <= '0;
        dy_q[k] <= '0;
      end
      de1_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_BALLS; k++) begin
        dx_q[k] <= dx_d[k];
        dy_q[k] <= dy_d[k];
      end
      de1_q <= i_disp_enbl;
    end
  end

  // Stage 2: squared distance against radius; squares stay below 2^23 so 24-bit signed math is exact.
  logic signed [23:0] dx_ext [N_BALLS];
  logic signed [23:0] dy_ext [N_BALLS];
  logic [23:0]        dist_sq [N_BALLS];
  logic [N_BALLS-1:0] hit_d;
  logic [N_BALLS-1:0] hit_q;
  logic               safe2_q;
  logic               de2_q;

  always_comb begin
    hit_d = '0;
    for (int k = 0; k < N_BALLS; k++) begin
      dx_ext[k]  = {{12{dx_q[k][11]}}, dx_q[k]};
      dy_ext[k]  = {{13{dy_q[k][10]}}, dy_q[k]};
      dist_sq[k] = 24'(dx_ext[k] * dx_ext[k]) + 24'(dy_ext[k] * dy_ext[k]);
      hit_d[k]   = (dist_sq[k] <= RADIUS_SQ) && visible[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_q   <= '0;
      safe2_q <= 1'b0;
      de2_q   <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      safe2_q <= i_is_safe;
      de2_q   <= de1_q;
    end
  end

  // Stage 3: lowest-index ball wins, then safe zone, then background; blanking forces black.
  logic [11:0] color_d;
  logic [11:0] color_q;
  logic        de3_q;

  always_comb begin
    color_d = safe2_q ? SAFE_COLOR : BKG_COLOR;
    for (int k = N_BALLS - 1; k >= 0; k--) begin
      if (hit_q[k]) begin
        color_d = BALL_COLORS[12*k +: 12];
      end
    end
    if (!de2_q) begin
      color_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      color_q <= '0;
      de3_q   <= 1'b0;
    end else begin
      color_q <= color_d;
      de3_q   <= de2_q;
    end
  end

  assign o_red       = color_q[11:8];
  assign o_green     = color_q[7:4];
  assign o_blue      = color_q[3:0];
  assign o_disp_enbl = de3_q;

endmodule
